// File: rtl/lcd_tx_sequencer_pkg.sv
// Shared types and constants for the LCD transmit sequencer.
// FIFO words are {is_cmd, byte}; ROM entries are {is_delay, word}.
package lcd_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_RD,
    S_INIT_PUSH,
    S_INIT_WAIT,
    S_PG_CMD,
    S_FB_RD,
    S_FB_PUSH,
    S_DONE
  } state_t;

  localparam int CMD_BIT = 8;
  localparam int DLY_BIT = 9;
  localparam int ROM_AW  = 4;

  localparam logic [7:0] SET_PAGE = 8'hB0;
  localparam logic [7:0] COL_HI   = 8'h10;
  localparam logic [7:0] COL_LO   = 8'h00;

  function automatic logic [8:0] cmd_word(
    input logic [7:0] op
  );
    return {1'b1, op};
  endfunction

endpackage

// File: rtl/lcd_tx_sequencer_rom.sv
// Power-up init script for the DOGS-style controller.
// Delay entries carry a count of delay units in bits [7:0].
module lcd_tx_sequencer_rom
  import lcd_tx_sequencer_pkg::*;
(
  input  logic [ROM_AW-1:0] i_addr,
  output logic [9:0]        o_entry
);

  always_comb begin
    o_entry = 10'h000;
    case (i_addr)
      4'd0:  o_entry = 10'h1E2;
      4'd1:  o_entry = 10'h202;
      4'd2:  o_entry = 10'h140;
      4'd3:  o_entry = 10'h1A1;
      4'd4:  o_entry = 10'h1C0;
      4'd5:  o_entry = 10'h1A6;
      4'd6:  o_entry = 10'h1A2;
      4'd7:  o_entry = 10'h12F;
      4'd8:  o_entry = 10'h200;
      4'd9:  o_entry = 10'h127;
      4'd10: o_entry = 10'h181;
      4'd11: o_entry = 10'h110;
      4'd12: o_entry = 10'h1FA;
      4'd13: o_entry = 10'h190;
      4'd14: o_entry = 10'h201;
      4'd15: o_entry = 10'h1AF;
    endcase
  end

endmodule

// File: rtl/lcd_tx_sequencer.sv
// LCD transmit sequencer: init script, framebuffer refresh
// and CPU direct writes, all feeding one 9-bit FIFO.
module lcd_tx_sequencer
  import lcd_tx_sequencer_pkg::*;
#(
  parameter int PAGES      = 8,
  parameter int COLS       = 102,
  parameter int INIT_LEN   = 16,
  parameter int DELAY_TICK = 100000,
  parameter int FB_AW      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start_init,
  input  logic             i_refresh_req,
  output logic             o_busy,
  output logic             o_done,
  input  logic             i_cpu_wr,
  input  logic [8:0]       i_cpu_din,
  output logic             o_cpu_ready,
  output logic [FB_AW-1:0] o_fb_addr,
  input  logic [7:0]       i_fb_data,
  output logic             o_fifo_wr,
  output logic [8:0]       o_fifo_din,
  input  logic             i_fifo_full
);

  localparam int TW = $clog2(DELAY_TICK + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_init_pend;
  logic              r_frame_pend;
  logic [ROM_AW-1:0] r_idx;
  logic [3:0]        r_page;
  logic [7:0]        r_col;
  logic [1:0]        r_cmd_n;
  logic [7:0]        r_units;
  logic [TW-1:0]     r_tick;
  logic [7:0]        r_fb_data;
  logic              r_fb_hold;
  logic              r_fifo_wr;
  logic [8:0]        r_fifo_din;

  logic [9:0] w_entry;
  logic [8:0] w_word;
  logic [7:0] w_byte;
  logic       w_push;
  logic       w_go;
  logic       w_idle;
  logic       w_tick_end;
  logic       w_wait_end;
  logic       w_last_idx;
  logic       w_last_col;
  logic       w_last_page;
  logic       w_take_init;
  logic       w_take_frame;

  lcd_tx_sequencer_rom u_rom (
    .i_addr  (r_idx),
    .o_entry (w_entry)
  );

  assign w_idle      = (r_state == S_IDLE);
  assign w_go        = w_push & ~i_fifo_full;
  assign w_last_idx  = (r_idx == ROM_AW'(INIT_LEN - 1));
  assign w_last_col  = (r_col == 8'(COLS - 1));
  assign w_last_page = (r_page == 4'(PAGES - 1));
  assign w_tick_end  = (r_tick == TW'(DELAY_TICK - 1));
  assign w_byte      = r_fb_hold ? r_fb_data : i_fb_data;

  // Expire on the last tick of the last unit; zero units take one cycle.
  assign w_wait_end = (r_units == 8'd0) |
                      ((r_units == 8'd1) & w_tick_end);

  assign w_take_init  = w_idle & r_init_pend;
  assign w_take_frame = w_idle & ~r_init_pend & r_frame_pend;

  assign o_busy      = ~w_idle | r_init_pend | r_frame_pend;
  assign o_done      = (r_state == S_DONE);
  assign o_cpu_ready = w_idle & ~r_init_pend & ~r_frame_pend &
                       ~i_fifo_full & ~rst;
  assign o_fb_addr   = FB_AW'(r_page) * FB_AW'(COLS) + FB_AW'(r_col);
  assign o_fifo_wr   = r_fifo_wr;
  assign o_fifo_din  = r_fifo_din;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_word      = 9'h000;
    unique case (r_state)
      S_IDLE: begin
        if (r_init_pend) begin
          w_state_nxt = S_INIT_RD;
        end else if (r_frame_pend) begin
          w_state_nxt = S_PG_CMD;
        end else if (i_cpu_wr & o_cpu_ready) begin
          w_push = 1'b1;
          w_word = i_cpu_din;
        end
      end
      S_INIT_RD: begin
        w_state_nxt = w_entry[DLY_BIT] ? S_INIT_WAIT
                                       : S_INIT_PUSH;
      end
      S_INIT_PUSH: begin
        w_push = 1'b1;
        w_word = w_entry[8:0];
        if (!i_fifo_full)
          w_state_nxt = w_last_idx ? S_DONE : S_INIT_RD;
      end
      S_INIT_WAIT: begin
        if (w_wait_end)
          w_state_nxt = w_last_idx ? S_DONE : S_INIT_RD;
      end
      S_PG_CMD: begin
        w_push = 1'b1;
        if (r_cmd_n == 2'd0)
          w_word = cmd_word(SET_PAGE | {4'h0, r_page});
        else if (r_cmd_n == 2'd1)
          w_word = cmd_word(COL_HI | {4'h0, r_col[7:4]});
        else
          w_word = cmd_word(COL_LO | {4'h0, r_col[3:0]});
        if (!i_fifo_full && r_cmd_n == 2'd2)
          w_state_nxt = S_FB_RD;
      end
      S_FB_RD: begin
        w_state_nxt = S_FB_PUSH;
      end
      S_FB_PUSH: begin
        w_push = 1'b1;
        w_word = {1'b0, w_byte};
        if (!i_fifo_full) begin
          if (!w_last_col)
            w_state_nxt = S_FB_RD;
          else
            w_state_nxt = w_last_page ? S_DONE : S_PG_CMD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_init_pend  <= 1'b0;
      r_frame_pend <= 1'b0;
      r_idx        <= '0;
      r_page       <= '0;
      r_col        <= '0;
      r_cmd_n      <= '0;
      r_units      <= '0;
      r_tick       <= '0;
      r_fb_data    <= '0;
      r_fb_hold    <= 1'b0;
      r_fifo_wr    <= 1'b0;
      r_fifo_din   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fifo_wr    <= w_go;
      r_init_pend  <= i_start_init | (r_init_pend & ~w_take_init);
      r_frame_pend <= i_refresh_req |
                      (r_frame_pend & ~w_take_frame);
      if (w_go)
        r_fifo_din <= w_word;
      unique case (r_state)
        S_IDLE: begin
          r_idx   <= '0;
          r_page  <= '0;
          r_col   <= '0;
          r_cmd_n <= '0;
        end
        S_INIT_RD: begin
          r_units <= w_entry[7:0];
          r_tick  <= '0;
        end
        S_INIT_PUSH: begin
          if (w_go && !w_last_idx)
            r_idx <= r_idx + 1'b1;
        end
        S_INIT_WAIT: begin
          if (w_wait_end) begin
            if (!w_last_idx)
              r_idx <= r_idx + 1'b1;
          end else if (w_tick_end) begin
            r_tick  <= '0;
            r_units <= r_units - 1'b1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_PG_CMD: begin
          if (w_go)
            r_cmd_n <= (r_cmd_n == 2'd2) ? 2'd0
                                         : r_cmd_n + 1'b1;
        end
        S_FB_PUSH: begin
          if (!r_fb_hold)
            r_fb_data <= i_fb_data;
          r_fb_hold <= ~w_go;
          if (w_go) begin
            if (!w_last_col) begin
              r_col <= r_col + 1'b1;
            end else begin
              r_col <= '0;
              if (!w_last_page)
                r_page <= r_page + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_tx_sequencer.sv
// Scoreboard bench for lcd_tx_sequencer: expected FIFO words are
// queued from a script/frame model and popped on every fifo_wr.
module tb_lcd_tx_sequencer;

  localparam int PAGES = 2;
  localparam int COLS  = 4;
  localparam int DT    = 10;
  localparam int NFB   = PAGES * COLS;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start_init;
  logic       i_refresh_req;
  logic       o_busy;
  logic       o_done;
  logic       i_cpu_wr;
  logic [8:0] i_cpu_din;
  logic       o_cpu_ready;
  logic [9:0] o_fb_addr;
  logic [7:0] i_fb_data;
  logic       o_fifo_wr;
  logic [8:0] o_fifo_din;
  logic       i_fifo_full;

  lcd_tx_sequencer #(
    .PAGES(PAGES), .COLS(COLS), .INIT_LEN(16),
    .DELAY_TICK(DT), .FB_AW(10)
  ) dut (
    .clk(clk), .rst(rst),
    .i_start_init(i_start_init), .i_refresh_req(i_refresh_req),
    .o_busy(o_busy), .o_done(o_done),
    .i_cpu_wr(i_cpu_wr), .i_cpu_din(i_cpu_din),
    .o_cpu_ready(o_cpu_ready),
    .o_fb_addr(o_fb_addr), .i_fb_data(i_fb_data),
    .o_fifo_wr(o_fifo_wr), .o_fifo_din(o_fifo_din),
    .i_fifo_full(i_fifo_full)
  );

  always #5 clk = ~clk;

  logic [9:0] rom_tb [16] = '{
    10'h1E2, 10'h202, 10'h140, 10'h1A1,
    10'h1C0, 10'h1A6, 10'h1A2, 10'h12F,
    10'h200, 10'h127, 10'h181, 10'h110,
    10'h1FA, 10'h190, 10'h201, 10'h1AF
  };

  logic [7:0] fb_mem [NFB];
  logic [8:0] exp_q [$];
  int         wr_times [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  bit rand_full = 0;
  bit force_full = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    i_fb_data <= (o_fb_addr < 10'(NFB)) ? fb_mem[o_fb_addr[2:0]] : 8'h00;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    logic [8:0] w;
    i_fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_done) done_cnt++;
        if (o_fifo_wr) begin
          wr_cnt++;
          wr_times.push_back(cyc);
          chk("wr_while_full", int'(i_fifo_full), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", int'(o_fifo_din), -1);
          end else begin
            w = exp_q.pop_front();
            chk("fifo_word", int'(o_fifo_din), int'(w));
          end
        end
      end
      if (rand_full)
        i_fifo_full = o_fifo_wr ? 1'b0 : 1'($urandom_range(0, 1));
      else
        i_fifo_full = force_full;
    end
  end

  task automatic expect_init();
    foreach (rom_tb[i])
      if (!rom_tb[i][9]) exp_q.push_back(rom_tb[i][8:0]);
  endtask

  task automatic expect_frame();
    for (int p = 0; p < PAGES; p++) begin
      exp_q.push_back({1'b1, 8'hB0 | 8'(p)});
      exp_q.push_back(9'h110);
      exp_q.push_back(9'h100);
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({1'b0, fb_mem[p * COLS + c]});
    end
  endtask

  task automatic pulse(input logic si, input logic rr);
    @(negedge clk);
    i_start_init  = si;
    i_refresh_req = rr;
    @(negedge clk);
    i_start_init  = 1'b0;
    i_refresh_req = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget,
                           input string name);
    int base = done_cnt;
    int k = 0;
    while (done_cnt < base + n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt < base + n)
      chk({name, "_timeout"}, done_cnt - base, n);
  endtask

  initial begin
    int base, k, acc, cost, d, nd, lowc;
    bit first;
    rst = 1'b1;
    i_start_init = 0; i_refresh_req = 0;
    i_cpu_wr = 0; i_cpu_din = 0;
    for (int i = 0; i < NFB; i++) fb_mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_cpu_ready", int'(o_cpu_ready), 0);
    chk("rst_fifo_wr", int'(o_fifo_wr), 0);
    chk("rst_fifo_din", int'(o_fifo_din), 0);
    chk("rst_fb_addr", int'(o_fb_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cpu_ready", int'(o_cpu_ready), 1);

    // init script with timing between pushes
    wr_times.delete();
    base = done_cnt;
    expect_init();
    pulse(1'b1, 1'b0);
    wait_done(1, 2000, "init");
    repeat (5) @(negedge clk);
    chk("init_done_once", done_cnt - base, 1);
    chk("init_words", wr_times.size(), 13);
    k = 0; acc = 0; first = 1;
    for (int i = 0; i < 16; i++) begin
      d = int'(rom_tb[i][7:0]);
      cost = rom_tb[i][9] ? 1 + ((d * DT > 0) ? d * DT : 1) : 2;
      if (!first) acc += cost;
      if (!rom_tb[i][9]) begin
        if (!first && k < wr_times.size())
          chk("init_gap", wr_times[k] - wr_times[k-1], acc);
        first = 0; k++; acc = 0;
      end
    end

    // plain frame
    base = done_cnt;
    wr_cnt = 0;
    expect_frame();
    pulse(1'b0, 1'b1);
    wait_done(1, 2000, "frame");
    repeat (5) @(negedge clk);
    chk("frame_pushes", wr_cnt, 14);
    chk("frame_done_once", done_cnt - base, 1);

    // frames under random backpressure
    for (int r = 0; r < 3; r++) begin
      if (r > 0)
        for (int i = 0; i < NFB; i++) fb_mem[i] = 8'($urandom);
      expect_frame();
      rand_full = 1;
      pulse(1'b0, 1'b1);
      wait_done(1, 3000, "bp_frame");
      rand_full = 0;
      repeat (5) @(negedge clk);
      chk("bp_queue_empty", exp_q.size(), 0);
    end

    // coalesced requests: init then exactly one frame
    base = done_cnt;
    expect_init();
    expect_frame();
    @(negedge clk);
    i_start_init = 1; i_refresh_req = 1;
    lowc = 0; nd = 0;
    forever begin
      @(posedge clk); #1;
      if (nd == 0) begin i_start_init = 0; i_refresh_req = 0; end
      if (nd == 30) i_refresh_req = 1;
      if (nd == 31) i_refresh_req = 0;
      nd++;
      if (done_cnt >= base + 2 || nd > 5000) break;
      if (!o_busy) lowc++;
    end
    chk("coal_busy_low", lowc, 0);
    repeat (30) @(negedge clk);
    chk("coal_dones", done_cnt - base, 2);
    chk("coal_queue_empty", exp_q.size(), 0);

    // CPU direct writes
    @(negedge clk);
    chk("cpu_ready_idle", int'(o_cpu_ready), 1);
    i_cpu_wr = 1; i_cpu_din = 9'h1AF;
    exp_q.push_back(9'h1AF);
    @(negedge clk);
    i_cpu_wr = 0;
    chk("cpu_next_wr", int'(o_fifo_wr), 1);
    chk("cpu_next_din", int'(o_fifo_din), 9'h1AF);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_cpu_din = 9'($urandom);
      exp_q.push_back(i_cpu_din);
      i_cpu_wr = 1;
      @(negedge clk);
      i_cpu_wr = 0;
    end
    force_full = 1;
    repeat (2) @(negedge clk);
    chk("cpu_ready_full", int'(o_cpu_ready), 0);
    i_cpu_wr = 1; i_cpu_din = 9'h055;
    repeat (3) @(negedge clk);
    i_cpu_wr = 0;
    force_full = 0;
    repeat (2) @(negedge clk);

    // CPU word and refresh in the same cycle
    base = done_cnt;
    i_cpu_din = 9'($urandom);
    exp_q.push_back(i_cpu_din);
    expect_frame();
    i_cpu_wr = 1; i_refresh_req = 1;
    @(negedge clk);
    i_cpu_wr = 0; i_refresh_req = 0;
    lowc = 0; nd = 0;
    while (done_cnt < base + 1 && nd < 2000) begin
      @(posedge clk); #1;
      if (done_cnt < base + 1 && o_cpu_ready) lowc++;
      nd++;
    end
    chk("frame_cpu_ready", lowc, 0);
    repeat (5) @(negedge clk);
    chk("cpu_frame_queue", exp_q.size(), 0);

    // reset inside FB_PUSH
    expect_frame();
    pulse(1'b0, 1'b1);
    k = 0; nd = 0;
    while (k < 2 && nd < 500) begin
      @(negedge clk);
      if (o_fifo_wr && !o_fifo_din[8]) k++;
      nd++;
    end
    chk("find_fb_push", k, 2);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_wr", int'(o_fifo_wr), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    base = done_cnt;
    expect_frame();
    pulse(1'b0, 1'b1);
    wait_done(1, 2000, "restart");
    repeat (5) @(negedge clk);
    chk("restart_queue", exp_q.size(), 0);
    chk("restart_done", done_cnt - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
